// File: rtl/qpsk_symbol_deframer.sv
// QPSK symbol deframer: decimates hard decisions, hunts for a 16-bit sync word,
// packs a fixed-length payload into bytes and queues them in a 4-deep show-ahead FIFO.
module qpsk_symbol_deframer #(
    parameter int unsigned SPS         = 16,
    parameter logic [15:0] SYNC_WORD   = 16'h1ACF,
    parameter int unsigned PAYLOAD_LEN = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] symbol_in,
    input  logic       symbol_valid,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       in_frame,
    output logic       frame_start,
    output logic       frame_end,
    output logic       overflow
);

    localparam int unsigned SW = (SPS > 2) ? $clog2(SPS) : 1;
    localparam logic [SW-1:0] DEC_AT  = SW'(SPS / 2 - 1);
    localparam logic [SW-1:0] SCNT_MAX = SW'(SPS - 1);
    localparam logic [7:0]    LAST_BYTE = 8'(PAYLOAD_LEN - 1);

    typedef enum logic {
        HUNT,
        PAYLOAD
    } state_t;

    state_t        state;
    logic [SW-1:0] scnt;
    logic [15:0]   sr;
    logic [1:0]    sym_cnt;
    logic [5:0]    acc;
    logic [7:0]    byte_cnt;

    logic [7:0]    mem [4];
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [2:0]    count;

    logic          dec;
    logic [15:0]   nsr;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic [7:0]    new_byte;
    logic [1:0]    rd_ptr_nxt;
    logic [2:0]    count_nxt;
    logic [7:0]    head_nxt;

    always_comb begin
        dec        = symbol_valid && (scnt == DEC_AT);
        nsr        = {sr[13:0], symbol_in};
        new_byte   = {acc, symbol_in};
        push       = dec && (state == PAYLOAD) && (sym_cnt == 2'd3);
        pop        = byte_ready && (count != 3'd0);
        push_ok    = push && ((count != 3'd4) || pop);
        rd_ptr_nxt = pop ? rd_ptr + 2'd1 : rd_ptr;
        count_nxt  = count;
        unique case ({push_ok, pop})
            2'b10:   count_nxt = count + 3'd1;
            2'b01:   count_nxt = count - 3'd1;
            default: count_nxt = count;
        endcase
        // Head register sees the post-write memory so a push into an empty FIFO shows next cycle.
        head_nxt = (push_ok && (wr_ptr == rd_ptr_nxt)) ? new_byte : mem[rd_ptr_nxt];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= HUNT;
            scnt        <= '0;
            sr          <= '0;
            sym_cnt     <= '0;
            acc         <= '0;
            byte_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            in_frame    <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_end   <= 1'b0;

            if (symbol_valid) begin
                scnt <= (scnt == SCNT_MAX) ? '0 : scnt + 1'b1;
            end

            if (dec) begin
                sr <= nsr;
                unique case (state)
                    HUNT: begin
                        if (nsr == SYNC_WORD) begin
                            state       <= PAYLOAD;
                            in_frame    <= 1'b1;
                            frame_start <= 1'b1;
                            sym_cnt     <= '0;
                            byte_cnt    <= '0;
                        end
                    end
                    PAYLOAD: begin
                        acc     <= {acc[3:0], symbol_in};
                        sym_cnt <= sym_cnt + 2'd1;
                        if (sym_cnt == 2'd3) begin
                            byte_cnt <= byte_cnt + 8'd1;
                            if (byte_cnt == LAST_BYTE) begin
                                state     <= HUNT;
                                in_frame  <= 1'b0;
                                frame_end <= 1'b1;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end

            if (push_ok) begin
                mem[wr_ptr] <= new_byte;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            rd_ptr     <= rd_ptr_nxt;
            count      <= count_nxt;
            byte_valid <= (count_nxt != 3'd0);
            byte_data  <= head_nxt;
        end
    end

endmodule

// File: tb/tb_qpsk_symbol_deframer.sv
// Self-checking bench: directed frame scenarios with randomized payload, ready and gaps,
// compared every cycle against a queue-based behavioural model.
module tb_qpsk_symbol_deframer;

    localparam int unsigned SPS  = 4;
    localparam int unsigned LEN  = 6;
    localparam logic [15:0] SYNC = 16'h1ACF;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] symbol_in = '0;
    logic       symbol_valid = 1'b0;
    logic       byte_ready = 1'b0;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       in_frame;
    logic       frame_start;
    logic       frame_end;
    logic       overflow;

    qpsk_symbol_deframer #(
        .SPS(SPS),
        .SYNC_WORD(SYNC),
        .PAYLOAD_LEN(LEN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .symbol_in(symbol_in),
        .symbol_valid(symbol_valid),
        .byte_data(byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .in_frame(in_frame),
        .frame_start(frame_start),
        .frame_end(frame_end),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int unsigned m_samp;
    int unsigned m_hist;
    int unsigned m_cur;
    int unsigned m_syms;
    int unsigned m_bytes;
    bit          m_in_frame;
    bit          m_fs;
    bit          m_fe;
    bit          m_ovf;
    logic [7:0]  m_fifo[$];

    logic [7:0]  fb [LEN];

    task automatic model_reset();
        m_samp = 0; m_hist = 0; m_cur = 0; m_syms = 0; m_bytes = 0;
        m_in_frame = 0; m_fs = 0; m_fe = 0; m_ovf = 0;
        m_fifo.delete();
    endtask

    task automatic model_edge(input logic [1:0] sym, input logic v, input logic rdy);
        bit         dec = 0;
        bit         push = 0;
        bit         pop;
        logic [7:0] pb = '0;
        if (!reset) begin
            model_reset();
            return;
        end
        pop  = rdy && (m_fifo.size() > 0);
        m_fs = 0;
        m_fe = 0;
        if (v) begin
            dec    = (m_samp == SPS / 2 - 1);
            m_samp = (m_samp + 1) % SPS;
        end
        if (dec) begin
            m_hist = ((m_hist << 2) | sym) & 32'hFFFF;
            if (!m_in_frame) begin
                if (m_hist == SYNC) begin
                    m_in_frame = 1; m_fs = 1; m_syms = 0; m_bytes = 0;
                end
            end else begin
                m_cur = ((m_cur << 2) | sym) & 32'hFF;
                m_syms++;
                if (m_syms % 4 == 0) begin
                    push = 1;
                    pb   = m_cur[7:0];
                    m_bytes++;
                    if (m_bytes == LEN) begin
                        m_in_frame = 0; m_fe = 1;
                    end
                end
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (push) begin
            if (m_fifo.size() < 4) m_fifo.push_back(pb);
            else m_ovf = 1;
        end
    endtask

    task automatic check(input string tag);
        logic [12:0] exp_v;
        logic [12:0] got_v;
        logic        ev;
        logic [7:0]  ed;
        ev    = (m_fifo.size() > 0);
        ed    = ev ? m_fifo[0] : 8'h00;
        exp_v = {ev, ed, m_in_frame, m_fs, m_fe, m_ovf};
        got_v = {byte_valid, (byte_valid ? byte_data : 8'h00), in_frame, frame_start, frame_end, overflow};
        vectors++;
        assert (got_v === exp_v) else begin
            miscompares++;
            $error("FAIL %s t=%0t observed={v,data,in_frame,fs,fe,ovf}=%h expected=%h", tag, $time, got_v, exp_v);
        end
    endtask

    task automatic step(input logic [1:0] sym, input logic v, input logic rdy, input string tag);
        symbol_in    = sym;
        symbol_valid = v;
        byte_ready   = rdy;
        @(posedge clk);
        model_edge(sym, v, rdy);
        #1;
        check(tag);
    endtask

    // rmode: 0 ready high, 1 ready low, 2 random, 3 low except a pulse on the dec sample
    task automatic send_sym(input logic [1:0] sym, input bit corrupt, input int rmode,
                            input bit pulse, input bit gaps, input string tag);
        logic [1:0] s;
        logic       r;
        for (int k = 0; k < SPS; k++) begin
            if (gaps && ($urandom % 4 == 0))
                step(2'($urandom), 1'b0, (rmode == 0) || (rmode == 2 && $urandom % 2 == 1), tag);
            s = (corrupt && (k == 0 || k == SPS - 1)) ? 2'($urandom) : sym;
            case (rmode)
                0:       r = 1'b1;
                1:       r = 1'b0;
                2:       r = 1'($urandom);
                default: r = pulse && (k == SPS / 2 - 1);
            endcase
            step(s, 1'b1, r, tag);
        end
    endtask

    task automatic send_frame(input int nbytes, input bit corrupt, input int rmode,
                              input int pulse_byte, input bit gaps, input string tag);
        logic [15:0] sw;
        logic [7:0]  b;
        sw = SYNC;
        for (int i = 7; i >= 0; i--)
            send_sym(sw[2*i +: 2], corrupt, rmode, 1'b0, gaps, tag);
        for (int n = 0; n < nbytes; n++) begin
            b = fb[n];
            for (int j = 3; j >= 0; j--)
                send_sym(b[2*j +: 2], corrupt, rmode, (n == pulse_byte) && (j == 0), gaps, tag);
        end
    endtask

    task automatic drain(input int n, input string tag);
        for (int i = 0; i < n; i++) step(2'b00, 1'b0, 1'b1, tag);
    endtask

    task automatic random_bytes();
        for (int i = 0; i < LEN; i++) fb[i] = 8'($urandom);
    endtask

    initial begin
        model_reset();

        // Reset values
        for (int i = 0; i < 3; i++) step(2'b00, 1'b0, 1'b0, "reset_hold");
        vectors++;
        assert (byte_data === 8'h00) else begin
            miscompares++;
            $error("FAIL reset_byte_data observed=%h expected=00", byte_data);
        end
        reset = 1'b1;
        for (int i = 0; i < 100; i++) step(2'b00, 1'b1, 1'b1, "idle_zero");

        // Sync + frame with known bytes, then same with corrupted non-decision samples
        for (int i = 0; i < LEN; i++) fb[i] = 8'($urandom);
        fb[0] = 8'hE4;
        fb[1] = 8'h1B;
        send_frame(LEN, 1'b0, 0, -1, 1'b0, "frame_clean");
        drain(4, "drain_clean");
        send_frame(LEN, 1'b1, 0, -1, 1'b0, "frame_corrupt");
        drain(4, "drain_corrupt");

        // Backpressure: FIFO fills, last bytes dropped, then drained
        random_bytes();
        send_frame(LEN, 1'b0, 1, -1, 1'b0, "frame_backpressure");
        drain(8, "drain_backpressure");

        // Reset mid-frame: one byte in flight, asynchronous clear
        reset = 1'b0;
        step(2'b00, 1'b0, 1'b0, "reset_pre");
        reset = 1'b1;
        random_bytes();
        send_frame(1, 1'b0, 1, -1, 1'b0, "frame_partial");
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        assert ({byte_valid, in_frame} === 2'b00) else begin
            miscompares++;
            $error("FAIL async_reset observed={byte_valid,in_frame}=%b expected=00", {byte_valid, in_frame});
        end
        model_reset();
        step(2'b00, 1'b0, 1'b0, "reset_mid");
        step(2'b00, 1'b0, 1'b0, "reset_mid");
        reset = 1'b1;

        // Push and pop together while full on the fifth byte
        random_bytes();
        send_frame(LEN, 1'b0, 3, 4, 1'b0, "frame_full_pushpop");
        drain(8, "drain_full_pushpop");

        // Randomized frames with idle gaps, random ready and noise between frames
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 6; i++) send_sym(2'($urandom), 1'b0, 2, 1'b0, 1'b1, "noise");
            random_bytes();
            send_frame(LEN, 1'b0, 2, -1, 1'b1, "frame_random");
        end
        drain(8, "drain_final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
